// File: rtl/branch_redirect_ctrl_if.sv
// Bundle of the EX-side decision inputs, the fetch redirect handshake and the
// stale-response kill signals exchanged with branch_redirect_ctrl.
interface branch_redirect_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            pc_src;
    logic            stall;
    logic [XLEN-1:0] target_addr;
    logic            redir_ready;
    logic            imem_resp_valid;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            kill_resp;
    logic            busy;
    logic [31:0]     taken_cnt;

    modport master (
        output ex_valid, pc_src, stall, target_addr, redir_ready, imem_resp_valid,
        input  flush_if_id, flush_id_ex, redir_valid, redir_pc, kill_resp, busy, taken_cnt
    );

    modport slave (
        input  ex_valid, pc_src, stall, target_addr, redir_ready, imem_resp_valid,
        output flush_if_id, flush_id_ex, redir_valid, redir_pc, kill_resp, busy, taken_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer: squashes younger stages on a taken EX decision, issues
// the fetch redirect and drops the stale fetch responses still in flight.
module branch_redirect_ctrl #(
    parameter int XLEN       = 32,
    parameter int KILL_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    branch_redirect_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [2:0] KILL_INIT = 3'(KILL_DEPTH);

    state_t          state_r;
    logic [2:0]      kill_cnt_r;
    logic [XLEN-1:0] redir_pc_r;
    logic            redir_valid_r;
    logic [31:0]     taken_cnt_r;

    logic take_s;
    logic hs_s;
    logic kill_s;

    // Event decode; flushes must react in the take cycle itself, so they are not registered.
    always_comb begin
        take_s = bus.ex_valid & bus.pc_src & ~bus.stall & (state_r == IDLE);
        hs_s   = redir_valid_r & bus.redir_ready;
        kill_s = bus.imem_resp_valid & (state_r == DRAIN) & (kill_cnt_r != 3'd0);
    end

    // Redirect FSM with its registered request, target and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            kill_cnt_r    <= 3'd0;
            redir_pc_r    <= '0;
            redir_valid_r <= 1'b0;
            taken_cnt_r   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        redir_pc_r    <= bus.target_addr;
                        redir_valid_r <= 1'b1;
                        taken_cnt_r   <= taken_cnt_r + 32'd1;
                        state_r       <= REDIRECT;
                    end else begin
                        redir_valid_r <= 1'b0;
                    end
                end
                REDIRECT: begin
                    if (hs_s) begin
                        redir_valid_r <= 1'b0;
                        kill_cnt_r    <= KILL_INIT;
                        state_r       <= (KILL_INIT == 3'd0) ? IDLE : DRAIN;
                    end else begin
                        redir_valid_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    // A zero count here can only come from corruption; recover to IDLE.
                    if (kill_cnt_r == 3'd0) begin
                        state_r <= IDLE;
                    end else if (bus.imem_resp_valid) begin
                        kill_cnt_r <= kill_cnt_r - 3'd1;
                        if (kill_cnt_r == 3'd1) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    redir_valid_r <= 1'b0;
                    kill_cnt_r    <= 3'd0;
                end
            endcase
        end
    end

    assign bus.flush_if_id = take_s | (state_r != IDLE);
    assign bus.flush_id_ex = take_s;
    assign bus.redir_valid = redir_valid_r;
    assign bus.redir_pc    = redir_pc_r;
    assign bus.kill_resp   = kill_s;
    assign bus.busy        = (state_r != IDLE);
    assign bus.taken_cnt   = taken_cnt_r;
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the PC redirect after the EX-stage jump/branch decision resolves taken (`pc_src`). Squashes the younger IF/ID and ID/EX instructions and drives a redirect request to the fetch unit over a valid/ready handshake. It then discards the stale instruction-memory responses already in flight, and keeps a taken-redirect counter for performance checks. It sits between the EX-stage jump/branch decision logic and the fetch/PC unit.

## Interface
Parameters:
- `XLEN`, 32, address width of target and redirect PC
- `KILL_DEPTH`, 2, number of in-flight fetch responses to discard after a redirect (0..7)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `ex_valid` in 1: EX stage holds a valid instruction
- `pc_src` in 1: taken jump/branch decision for the EX instruction
- `stall` in 1: pipeline stall from hazard unit; EX instruction held
- `target_addr` in XLEN: jump/branch target of the EX instruction
- `redir_ready` in 1: fetch unit accepts redirect
- `imem_resp_valid` in 1: instruction memory returns a fetch response
- `flush_if_id` out 1: squash IF/ID register
- `flush_id_ex` out 1: squash ID/EX register
- `redir_valid` out 1: redirect request to fetch
- `redir_pc` out XLEN: redirect target
- `kill_resp` out 1: current `imem_resp_valid` response is stale and must be dropped
- `busy` out 1: controller not in IDLE
- `taken_cnt` out 32: number of accepted redirects

## Operation
- States: IDLE, REDIRECT, DRAIN.
- Event `take` = `ex_valid & pc_src & !stall & (state==IDLE)`.
- **IDLE**
  - `flush_if_id` = `flush_id_ex` = `take`, combinational in the same cycle.
  - On `take`: latch `target_addr` into `redir_pc`, increment `taken_cnt`, go to REDIRECT.
  - With `stall` high, no action; the event is re-evaluated every cycle until `stall` drops.
- **REDIRECT**
  - `redir_valid`=1 and `redir_pc` stable until the handshake (`redir_valid & redir_ready`).
  - `flush_if_id`=1.
  - On handshake: load kill counter with `KILL_DEPTH`. Go to DRAIN, or go directly to IDLE if `KILL_DEPTH`==0.
- **DRAIN**
  - `flush_if_id`=1.
  - `kill_resp` = `imem_resp_valid` while the counter > 0.
  - The counter decrements on each `imem_resp_valid`. The response that takes it to 0 moves the state to IDLE on the next cycle.
- `ex_valid`/`pc_src` outside IDLE are ignored: no latch, no count.
- `busy` = (state != IDLE).
- `taken_cnt`: 32-bit unsigned, wraps 0xFFFF_FFFF → 0, no saturation.
- Kill counter width: 3 bits.

## Timing
- All outputs reset to 0, including `redir_pc` and `taken_cnt`. State resets to IDLE, kill counter to 0.
- `rst` in any state (mid-REDIRECT with the request pending, or mid-DRAIN): next cycle is IDLE with all outputs 0. A pending redirect is dropped, not completed.
- `take` at cycle T:
  - flushes asserted in T
  - `redir_valid` high from T+1
  - `taken_cnt` updated at T+1
- Fastest redirect: `redir_ready` already high at T+1, so the handshake completes at T+1.
- Fastest return to IDLE:
  - `KILL_DEPTH`=0: IDLE at T+2.
  - Otherwise: IDLE one cycle after the last killed response.
- `redir_ready` held low: REDIRECT persists indefinitely with `redir_pc` unchanged.
- Handshake and `imem_resp_valid` in the same REDIRECT cycle: the response is not killed by this block. Fetch gates responses while a redirect is pending.
- `imem_resp_valid` in IDLE: `kill_resp`=0.
- `flush_id_ex` is only ever high in the `take` cycle.
- `flush_if_id` is high for `take` and all of REDIRECT/DRAIN.

## Test plan
- Reset, then `take` with `target_addr`=0x0000_0100 and `redir_ready`=1 → `flush_*`=1 at T; `redir_valid`=1, `redir_pc`=0x100, `taken_cnt`=1 at T+1; DRAIN; two `imem_resp_valid` pulses both give `kill_resp`=1; third pulse gives `kill_resp`=0; `busy`=0 after the second kill.
- `pc_src`=1, `ex_valid`=1 with `stall`=1 for 3 cycles, then `stall`=0 → no flush and no count during the stall; `take` fires in the first unstalled cycle.
- `redir_ready`=0 for 5 cycles in REDIRECT while `target_addr` changes to 0x200 and `pc_src` pulses → `redir_pc` stays 0x100, `taken_cnt` unchanged, handshake on cycle 6.
- `rst` asserted mid-REDIRECT, then mid-DRAIN with counter=1 → next cycle IDLE, `redir_valid`=0, `kill_resp`=0, `taken_cnt`=0.
- `KILL_DEPTH`=0 build: `take` then handshake → IDLE the cycle after the handshake, `kill_resp` never asserted.
- Preload 0xFFFF_FFFF redirects (or force `taken_cnt`) plus one `take` → `taken_cnt` wraps to 0.
